// File: rtl/elelock_param.sv
// N-digit ten-key door lock with failed-attempt lockout and idle timeout.
// Sits between the key scanner and the door actuator driver.
module elelock_param #(
  parameter int CODE_LEN = 4,
  parameter logic [4*CODE_LEN-1:0] SECRET = 16'h7319,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int IDLE_TIMEOUT = 5000,
  localparam int FW = $clog2(MAX_FAIL+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    tenkey,
  input  logic          enter,
  input  logic          close,
  output logic          lock,
  output logic          lockout,
  output logic          alarm,
  output logic [3:0]    digit_cnt,
  output logic [FW-1:0] fail_cnt
);

  localparam int W  = 4*CODE_LEN;
  localparam int IW = $clog2(IDLE_TIMEOUT+1);
  localparam int LW = $clog2(LOCKOUT_CYCLES+1);

  typedef enum logic [1:0] {
    S_LOCKED,
    S_ENTRY,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  state_t          state, state_n;
  logic [W-1:0]    code_buf, buf_n;
  logic [IW-1:0]   idle_cnt, idle_n;
  logic [LW-1:0]   lo_cnt, lo_n;
  logic [9:0]      prev_key;
  logic [3:0]      dcnt_n;
  logic [FW-1:0]   fcnt_n;
  logic            alarm_n;
  logic            press;
  logic            match;
  logic [3:0]      digit;
  logic [W+3:0]    shift_wide;
  logic [W-1:0]    shifted;

  // a press is a clean single-key edge out of all-released
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++)
      if (tenkey[i]) digit = 4'(i);
  end

  assign press      = $onehot(tenkey) && (prev_key == 10'd0);
  assign shift_wide = {code_buf, digit};
  assign shifted    = shift_wide[W-1:0];
  assign match      = (digit_cnt == 4'(CODE_LEN))
                   && (code_buf == SECRET);

  always_comb begin
    state_n = state;
    buf_n   = code_buf;
    dcnt_n  = digit_cnt;
    fcnt_n  = fail_cnt;
    idle_n  = idle_cnt;
    lo_n    = lo_cnt;
    alarm_n = 1'b0;
    unique case (state)
      S_LOCKED: begin
        if (press) begin
          buf_n   = shifted;
          dcnt_n  = 4'd1;
          idle_n  = '0;
          state_n = S_ENTRY;
        end
      end
      S_ENTRY: begin
        // enter wins over a simultaneous press
        if (enter) begin
          buf_n  = '0;
          dcnt_n = 4'd0;
          idle_n = '0;
          if (match) begin
            state_n = S_OPEN;
            fcnt_n  = '0;
          end else if (fail_cnt == FW'(MAX_FAIL-1)) begin
            state_n = S_LOCKOUT;
            fcnt_n  = FW'(MAX_FAIL);
            alarm_n = 1'b1;
            lo_n    = '0;
          end else begin
            state_n = S_LOCKED;
            fcnt_n  = fail_cnt + 1'b1;
          end
        end else if (press) begin
          buf_n  = shifted;
          idle_n = '0;
          if (digit_cnt != 4'(CODE_LEN))
            dcnt_n = digit_cnt + 4'd1;
        end else if (idle_cnt == IW'(IDLE_TIMEOUT-1)) begin
          state_n = S_LOCKED;
          buf_n   = '0;
          dcnt_n  = 4'd0;
          idle_n  = '0;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end
      S_OPEN: begin
        if (close) state_n = S_LOCKED;
      end
      S_LOCKOUT: begin
        if (lo_cnt == LW'(LOCKOUT_CYCLES-1)) begin
          state_n = S_LOCKED;
          fcnt_n  = '0;
          lo_n    = '0;
        end else begin
          lo_n = lo_cnt + 1'b1;
        end
      end
      default: state_n = S_LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOCKED;
      code_buf  <= '0;
      idle_cnt  <= '0;
      lo_cnt    <= '0;
      prev_key  <= 10'd0;
      lock      <= 1'b1;
      lockout   <= 1'b0;
      alarm     <= 1'b0;
      digit_cnt <= 4'd0;
      fail_cnt  <= '0;
    end else begin
      state     <= state_n;
      code_buf  <= buf_n;
      idle_cnt  <= idle_n;
      lo_cnt    <= lo_n;
      prev_key  <= tenkey;
      lock      <= (state_n != S_OPEN);
      lockout   <= (state_n == S_LOCKOUT);
      alarm     <= alarm_n;
      digit_cnt <= dcnt_n;
      fail_cnt  <= fcnt_n;
    end
  end

endmodule
